// File: rtl/io_responder.sv
// Memory-mapped button/LED responder: LED latch, debounced button level, sticky rise flags, IRQ mask.
// Latency: writes take effect at the ending edge; reads return DO combinationally, stretched by WAIT_STATES via RDY.
// Backpressure: RDY low stretches a CPU read; build with IO_RESPONDER_WAIT_EN for the wait FSM, otherwise RDY is tied high.
module io_responder #(
   parameter logic [15:0] BASE_ADDR       = 16'hD000,
   parameter int          WAIT_STATES     = 2,
   parameter int          DEBOUNCE_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        R,
   input  logic [15:0] AB,
   input  logic        WE,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   output logic        RDY,
   output logic        IRQ,
   input  logic [3:0]  BTN,
   output logic [7:0]  LED
);

   localparam logic [1:0] OFS_LED  = 2'd0;
   localparam logic [1:0] OFS_LVL  = 2'd1;
   localparam logic [1:0] OFS_FLAG = 2'd2;
   localparam logic [1:0] OFS_MASK = 2'd3;

   // Last count value before a debounced bit may toggle
   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic       sel;
   logic       wr_hit;
   logic       rd_hit;
   logic [3:0] mask;
   logic [3:0] flags;
   logic [3:0] level;
   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [7:0] db_cnt [4];
   logic [3:0] toggle;
   logic [3:0] rise;
   logic [3:0] clr;

   assign sel    = (AB[15:2] == BASE_ADDR[15:2]);
   assign wr_hit = sel & WE;
   assign rd_hit = sel & ~WE;

   // Read mux: only an in-window read cycle drives non-zero data
   always_comb begin
      DO = 8'h00;
      if (rd_hit) begin
         case (AB[1:0])
            OFS_LED:  DO = LED;
            OFS_LVL:  DO = {4'b0000, level};
            OFS_FLAG: DO = {4'b0000, flags};
            default:  DO = {4'b0000, mask};
         endcase
      end
   end

   // CPU-writable registers; BTNLVL and FLAGS have no plain write path
   always_ff @(posedge CLK) begin
      if (!R) begin
         LED  <= 8'h00;
         mask <= 4'h0;
      end else if (wr_hit) begin
         if (AB[1:0] == OFS_LED)  LED  <= DI;
         if (AB[1:0] == OFS_MASK) mask <= DI[3:0];
      end
   end

   // Two-flop synchronizer for the asynchronous buttons
   always_ff @(posedge CLK) begin
      if (!R) begin
         sync1 <= 4'h0;
         sync2 <= 4'h0;
      end else begin
         sync1 <= BTN;
         sync2 <= sync1;
      end
   end

   // A bit toggles on the edge that completes DEBOUNCE_CYCLES disagreeing cycles
   always_comb begin
      toggle = 4'h0;
      for (int i = 0; i < 4; i++) begin
         toggle[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   assign rise = toggle & ~level;
   assign clr  = (wr_hit && (AB[1:0] == OFS_FLAG)) ? DI[3:0] : 4'h0;

   // Per-bit debounce counters; any agreeing cycle restarts the count
   always_ff @(posedge CLK) begin
      if (!R) begin
         level <= 4'h0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= 8'h00;
      end else begin
         level <= level ^ toggle;
         for (int i = 0; i < 4; i++) begin
            if ((sync2[i] == level[i]) || toggle[i]) db_cnt[i] <= 8'h00;
            else                                     db_cnt[i] <= db_cnt[i] + 8'h01;
         end
      end
   end

   // Sticky rise flags; a rise beats a same-cycle write-1-to-clear
   always_ff @(posedge CLK) begin
      if (!R) flags <= 4'h0;
      else    flags <= (flags & ~clr) | rise;
   end

   assign IRQ = ~|(flags & mask);

`ifdef IO_RESPONDER_WAIT_EN
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic       WS_NZ   = (WAIT_STATES > 0);
   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t     state;
   logic [3:0] wcnt;
   logic       rd_req;

   // A new stretched read only starts out of reset with a non-zero wait count
   assign rd_req = R & rd_hit & WS_NZ;

   // RDY must drop in the very cycle the read appears, so it is decoded from state
   always_comb begin
      RDY = 1'b1;
      case (state)
         ST_IDLE: RDY = ~rd_req;
         ST_WAIT: RDY = (wcnt == 4'd0) | ~rd_hit;
         default: RDY = 1'b1;
      endcase
   end

   // Wait-state sequencer: count down, release for one cycle, or abort on a dropped read
   always_ff @(posedge CLK) begin
      if (!R) begin
         state <= ST_IDLE;
         wcnt  <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rd_req) begin
                  wcnt  <= WS_LOAD;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!rd_hit)              state <= ST_IDLE;
               else if (wcnt != 4'd0)    wcnt  <= wcnt - 4'd1;
               else                      state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   // Zero-wait build: every read completes in its first cycle
   assign RDY = 1'b1;
`endif

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hD000: base of the 4-byte register window.
REQ-002 SHALL have parameter WAIT_STATES, default 2: read wait cycles, legal range 0-15.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: stable cycles required per button, legal range 1-255.
REQ-004 SHALL have port CLK, input, 1: sole clock; all state changes on rising edge.
REQ-005 SHALL have port R, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port AB, input, 16: CPU address bus.
REQ-007 SHALL have port WE, input, 1: 1 = CPU write cycle, 0 = read.
REQ-008 SHALL have port DI, input, 8: write data from CPU.
REQ-009 SHALL have port DO, output, 8: read data to CPU.
REQ-010 SHALL have port RDY, output, 1: 0 stretches the current CPU read cycle.
REQ-011 SHALL have port IRQ, output, 1: active-low interrupt request.
REQ-012 SHALL have port BTN, input, 4: raw asynchronous button inputs.
REQ-013 SHALL have port LED, output, 8: LED latch, bit 7 = led1.

Function
REQ-014 SHALL decode sel = (AB[15:2] == BASE_ADDR[15:2]); offsets are: +0 LED (R/W), +1 BTNLVL (RO), +2 FLAGS (R, write-1-to-clear), +3 MASK (R/W).
REQ-015 SHALL drive DO combinationally to the register selected by AB[1:0] when sel and WE=0; otherwise DO SHALL be 8'h00.
REQ-016 SHALL return {4'b0, level[3:0]} for BTNLVL reads and {4'b0, flags[3:0]} for FLAGS reads; the upper nibble of MASK writes SHALL be ignored and read as 0.
REQ-017 SHALL update LED, MASK or FLAGS at the CLK edge ending a cycle with sel and WE=1; writes SHALL take no wait states, and writes to BTNLVL SHALL be ignored.
REQ-018 SHALL pass each BTN bit through a 2-flop synchronizer.
REQ-019 SHALL debounce each bit with its own counter: level[i] toggles after the synchronized bit has differed from level[i] for DEBOUNCE_CYCLES consecutive cycles, and the counter SHALL clear on any agreeing cycle.
REQ-020 SHALL set flags[i] on each cycle where level[i] rises 0->1.
REQ-021 SHALL give set priority over a simultaneous write-1-to-clear of the same bit.
REQ-022 SHALL NOT clear flags on a FLAGS read.
REQ-023 SHALL drive IRQ = ~|(flags & MASK[3:0]) combinationally.
REQ-024 SHALL implement a wait FSM with states IDLE and WAIT and a 4-bit counter wcnt.
REQ-025 In IDLE, on sel, WE=0 and WAIT_STATES>0, the FSM SHALL drive RDY=0, load wcnt<=WAIT_STATES-1 and go to WAIT.
REQ-026 In WAIT with wcnt!=0, the FSM SHALL drive RDY=0 and decrement wcnt.
REQ-027 In WAIT with wcnt==0, the FSM SHALL drive RDY=1 and return to IDLE.
REQ-028 A read SHALL therefore see exactly WAIT_STATES RDY-low cycles, followed by one RDY-high cycle in which DO is sampled.
REQ-029 In WAIT, if sel drops or WE=1, the FSM SHALL drive RDY=1 and abort to IDLE with no side effects.
REQ-030 Back-to-back reads of any in-window address SHALL each incur the full wait.
REQ-031 Accesses outside the window SHALL leave RDY=1 and all registers unchanged.

Reset
REQ-032 SHALL, with R=0 at a CLK edge, set LED=8'h00, MASK=0, flags=0, level=0, synchronizers=0, debounce counters=0, wcnt=0 and FSM=IDLE.
REQ-033 SHALL result in RDY=1, IRQ=1 and DO=8'h00 after reset is applied (no access in progress).
REQ-034 SHALL, on reset asserted mid-wait, return RDY to 1 in the cycle after the reset edge; reset SHALL override any simultaneous write or flag set.

Configuration
REQ-035 SHALL, with IO_RESPONDER_WAIT_EN defined, implement REQ-024..REQ-030.
REQ-036 SHALL, without IO_RESPONDER_WAIT_EN, tie RDY to 1, omit the FSM and counter, ignore WAIT_STATES, and complete all reads in one cycle.

Verification
REQ-037 Reset then write 8'hA5 to D000, read D000 -> LED=8'hA5, DO=8'hA5, reads of D004 and CFFF return 8'h00 with RDY=1.
REQ-038 WAIT_EN, WAIT_STATES=2, hold AB=D000 with WE=0 -> RDY low for 2 cycles, high on the 3rd; then AB=D001 -> another 2 low cycles.
REQ-039 BTN[0] 0->1 with glitches shorter than 4 cycles, then stable -> level[0] rises exactly 2+4 cycles after the stable edge, FLAGS=8'h01, IRQ stays 1 while MASK=0.
REQ-040 Write MASK=8'h01 with flag[0] set -> IRQ=0; write FLAGS=8'h01 -> IRQ=1; a new rising edge on the same cycle as the clear leaves flag[0]=1.
REQ-041 Assert R=0 during the 1st wait cycle with LED=8'hFF -> next cycle RDY=1, LED=8'h00, IRQ=1, FSM idle.
REQ-042 Build without IO_RESPONDER_WAIT_EN, read D003 -> RDY constantly 1, data valid in the same cycle.
